instruction_decode_stage: RTL and testbench
===========================================

INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 The block SHALL have these ports, one clock, with a synchronous active-high reset:
- CLK  in  1  single clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high.
- IR  in  32  fetched instruction word.
- IF_valid  in  1  IR holds a real instruction this cycle.
- EX_ready  in  1  downstream stage accepts the ID/EX register this cycle.
- WB_en  in  1  register-file write enable.
- WB_addr  in  5  write-back destination register.
- WB_data  in  32  write-back value.
- ID_ready  out  1  block can accept IR this cycle.
- ID_valid  out  1  ID/EX register holds a decoded instruction.
- RS_data  out  32  rs operand.
- RT_data  out  32  rt operand.
- IMM_ext  out  32  sign-extended IR[15:0].
- DEST_addr  out  5  destination register (rd for R-type, rt for I-type).
- ALU_op  out  3  ALU operation code.
- ALU_src, REG_write, MEM_read, MEM_write, MEM_to_reg, BRANCH, ILLEGAL  out  1 each  control bits.

Function
REQ-002 ID_ready SHALL equal EX_ready OR NOT ID_valid (combinational).
REQ-003 Accept: on posedge with ID_ready=1, the ID/EX register SHALL load the decode of IR, and ID_valid SHALL take the value of IF_valid. Latency is one cycle.
REQ-004 Stall: with ID_valid=1 and EX_ready=0, all ID/EX outputs SHALL hold their values, and IR SHALL be ignored.
REQ-005 Bubble: an accept with IF_valid=0 SHALL clear ID_valid and all control bits. Data fields are don't-care.
REQ-006 Decode, opcode IR[31:26] and funct IR[5:0]:
- R-type (0x00): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; REG_write=1; DEST_addr=IR[15:11].
- addi (0x08): ADD, ALU_src=1, REG_write=1, DEST_addr=IR[20:16].
- lw (0x23): ADD, ALU_src=1, MEM_read=1, MEM_to_reg=1, REG_write=1, DEST_addr=IR[20:16].
- sw (0x2B): ADD, ALU_src=1, MEM_write=1.
- beq (0x04): SUB, BRANCH=1.
REQ-007 Any other opcode or R-type funct SHALL set ILLEGAL=1 and clear REG_write, MEM_read, MEM_write and BRANCH. ID_valid is unaffected.
REQ-008 IMM_ext SHALL be {16{IR[15]}, IR[15:0]} for every instruction.
REQ-009 Register file: 32x32. Register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-010 Register-file writes SHALL occur on posedge when WB_en=1.
REQ-011 Read ports SHALL be combinational on IR[25:21] and IR[20:16].
REQ-012 Write-through bypass: if WB_en=1, WB_addr≠0 and WB_addr equals a read address in the same cycle, that port SHALL return WB_data.
REQ-013 Register-file writes SHALL proceed during a stall.

Reset
REQ-014 On posedge with RESET=1:
- ID_valid, all control bits and ILLEGAL SHALL be set to 0.
- RS_data, RT_data, IMM_ext, DEST_addr and ALU_op SHALL be set to 0.
- All 32 registers SHALL be set to 0.
REQ-015 RESET SHALL take priority over accept, stall and WB_en in the same cycle.
REQ-016 ID_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-017 A shared package SHALL hold the opcode constants, the funct constants, and the ALU_op encoding (ADD=0, SUB=1, AND=2, OR=3, SLT=4).
REQ-018 The register file SHALL be a sub-module named register_file, with two combinational read ports and one synchronous write port, including the bypass.
REQ-019 Decode logic and the ID/EX register SHALL reside in instruction_decode_stage.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then WB_en=1, WB_addr=5, WB_data=0x12345678; next IR=0x00A63020 (add $6,$5,$6), IF_valid=1 -> one cycle later ID_valid=1, RS_data=0x12345678, RT_data=0, DEST_addr=6, ALU_op=ADD, REG_write=1.
- IR=0x8C22FFFC (lw $2,-4($1)) -> IMM_ext=0xFFFFFFFC, DEST_addr=2, MEM_read=1, MEM_to_reg=1, ALU_src=1.
- Same cycle as decoding IR=0x00221820: WB_en=1, WB_addr=1, WB_data=0xDEADBEEF -> RS_data=0xDEADBEEF (bypass). Then write 0x5 to register 0 -> a later read of $0 returns 0.
- ID_valid=1 and EX_ready=0 for 3 cycles while IR changes -> outputs unchanged and ID_ready=0. EX_ready=1 -> new IR accepted next cycle.
- IR=0xFC000000 -> ILLEGAL=1 with REG_write=0, MEM_write=0, BRANCH=0. IF_valid=0 -> ID_valid=0 next cycle.
- RESET asserted during a stall with WB_en=1 -> ID_valid=0 next cycle, all registers read 0, and the write is discarded.

Source files
------------

// File: rtl/instruction_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage.
//   - Opcode constants (IR[31:26]) and R-type funct constants (IR[5:0]).
//   - ALU operation encoding driven on ALU_op.
//   - Control bundle carried through the ID/EX register.
package instruction_decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    illegal;
  } ctrl_t;

  // All-quiet control word: used for reset, bubbles and as the decode default.
  function automatic ctrl_t ctrl_none();
    ctrl_t c;
    c.alu_op     = ALU_ADD;
    c.alu_src    = 1'b0;
    c.reg_write  = 1'b0;
    c.mem_read   = 1'b0;
    c.mem_write  = 1'b0;
    c.mem_to_reg = 1'b0;
    c.branch     = 1'b0;
    c.illegal    = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/instruction_decode_stage_register_file.sv
// register_file: 32 x 32-bit general-purpose registers.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset (clears all registers)
//   rs_addr, rt_addr      combinational read addresses
//   rs_data, rt_data      read data, with write-through bypass from the write port
//   wr_en, wr_addr, wr_data  synchronous write port; writes to register 0 are dropped
module register_file
  import instruction_decode_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [32];

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Same-cycle write-through: a write landing on a read address is visible
  // immediately, so the decode stage never captures a stale operand.
  logic wr_live;
  assign wr_live = wr_en && (wr_addr != 5'd0);

  always_comb begin
    rs_data = '0;
    if (wr_live && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
    end else if (rs_addr != 5'd0) begin
      rs_data = regs[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (wr_live && (wr_addr == rt_addr)) begin
      rt_data = wr_data;
    end else if (rt_addr != 5'd0) begin
      rt_data = regs[rt_addr];
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: decodes IR, reads operands and holds the result in
// the ID/EX pipeline register.
// Ports:
//   CLK, RESET                    clock, synchronous active-high reset
//   IR, IF_valid                  instruction word and its valid flag from fetch
//   ID_ready                      this stage can take IR this cycle
//   ID_valid, EX_ready            ID/EX register valid, downstream acceptance
//   WB_en, WB_addr, WB_data       register-file write port (write-back)
//   RS_data, RT_data, IMM_ext     operands and sign-extended immediate
//   DEST_addr, ALU_op             destination register and ALU operation
//   ALU_src, REG_write, MEM_read, MEM_write, MEM_to_reg, BRANCH, ILLEGAL  control bits
//
// Handshake: upstream transfers when IF_valid is observed on a posedge with
// ID_ready=1; ID_valid=0 is a bubble. Downstream takes the ID/EX register on a
// posedge with ID_valid=1 and EX_ready=1. ID_ready = EX_ready | ~ID_valid, so
// the register reloads whenever it is empty or being drained, and holds
// (ignoring IR) while ID_valid=1 and EX_ready=0.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IR,
  input  logic        IF_valid,
  input  logic        EX_ready,
  input  logic        WB_en,
  input  logic [4:0]  WB_addr,
  input  logic [31:0] WB_data,
  output logic        ID_ready,
  output logic        ID_valid,
  output logic [31:0] RS_data,
  output logic [31:0] RT_data,
  output logic [31:0] IMM_ext,
  output logic [4:0]  DEST_addr,
  output logic [2:0]  ALU_op,
  output logic        ALU_src,
  output logic        REG_write,
  output logic        MEM_read,
  output logic        MEM_write,
  output logic        MEM_to_reg,
  output logic        BRANCH,
  output logic        ILLEGAL
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rs_rd;
  logic [31:0] rt_rd;
  logic [31:0] imm_d;
  logic [4:0]  dest_d;
  ctrl_t       ctrl_d;

  assign opcode  = IR[31:26];
  assign funct   = IR[5:0];
  assign rs_addr = IR[25:21];
  assign rt_addr = IR[20:16];
  assign rd_addr = IR[15:11];
  assign imm_d   = {{16{IR[15]}}, IR[15:0]};

  // Shift-amount field is not used by any supported instruction.
  logic unused_shamt;
  assign unused_shamt = ^IR[10:6];

  register_file u_register_file (
    .CLK     (CLK),
    .RESET   (RESET),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_rd),
    .rt_data (rt_rd),
    .wr_en   (WB_en),
    .wr_addr (WB_addr),
    .wr_data (WB_data)
  );

  // Decode. Anything unrecognised comes out as ILLEGAL with every side-effect
  // bit clear, so an illegal word can never write registers, memory or branch.
  always_comb begin
    ctrl_d = ctrl_none();
    dest_d = rt_addr;
    case (opcode)
      OP_RTYPE: begin
        dest_d           = rd_addr;
        ctrl_d.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl_d.alu_op = ALU_ADD;
          FN_SUB:  ctrl_d.alu_op = ALU_SUB;
          FN_AND:  ctrl_d.alu_op = ALU_AND;
          FN_OR:   ctrl_d.alu_op = ALU_OR;
          FN_SLT:  ctrl_d.alu_op = ALU_SLT;
          default: begin
            ctrl_d         = ctrl_none();
            ctrl_d.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_d.alu_op = ALU_SUB;
        ctrl_d.branch = 1'b1;
      end
      default: begin
        ctrl_d.illegal = 1'b1;
      end
    endcase
  end

  // ID/EX register
  logic        valid_q;
  ctrl_t       ctrl_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;
  logic [31:0] imm_q;
  logic [4:0]  dest_q;

  assign ID_ready = EX_ready || !valid_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 1'b0;
      ctrl_q  <= ctrl_none();
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      dest_q  <= '0;
    end else if (ID_ready) begin
      valid_q <= IF_valid;
      // A bubble carries no control; data fields still load but are unused.
      ctrl_q  <= IF_valid ? ctrl_d : ctrl_none();
      rs_q    <= rs_rd;
      rt_q    <= rt_rd;
      imm_q   <= imm_d;
      dest_q  <= dest_d;
    end
  end

  assign ID_valid   = valid_q;
  assign RS_data    = rs_q;
  assign RT_data    = rt_q;
  assign IMM_ext    = imm_q;
  assign DEST_addr  = dest_q;
  assign ALU_op     = ctrl_q.alu_op;
  assign ALU_src    = ctrl_q.alu_src;
  assign REG_write  = ctrl_q.reg_write;
  assign MEM_read   = ctrl_q.mem_read;
  assign MEM_write  = ctrl_q.mem_write;
  assign MEM_to_reg = ctrl_q.mem_to_reg;
  assign BRANCH     = ctrl_q.branch;
  assign ILLEGAL    = ctrl_q.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: reset state, decode of every
// supported instruction, bypass, register 0, stall, bubble, illegal and
// reset-during-stall.
module tb_instruction_decode_stage;

  logic        CLK;
  logic        RESET;
  logic [31:0] IR;
  logic        IF_valid;
  logic        EX_ready;
  logic        WB_en;
  logic [4:0]  WB_addr;
  logic [31:0] WB_data;
  logic        ID_ready;
  logic        ID_valid;
  logic [31:0] RS_data;
  logic [31:0] RT_data;
  logic [31:0] IMM_ext;
  logic [4:0]  DEST_addr;
  logic [2:0]  ALU_op;
  logic        ALU_src;
  logic        REG_write;
  logic        MEM_read;
  logic        MEM_write;
  logic        MEM_to_reg;
  logic        BRANCH;
  logic        ILLEGAL;

  int checks = 0;
  int failures = 0;

  instruction_decode_stage dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IR         (IR),
    .IF_valid   (IF_valid),
    .EX_ready   (EX_ready),
    .WB_en      (WB_en),
    .WB_addr    (WB_addr),
    .WB_data    (WB_data),
    .ID_ready   (ID_ready),
    .ID_valid   (ID_valid),
    .RS_data    (RS_data),
    .RT_data    (RT_data),
    .IMM_ext    (IMM_ext),
    .DEST_addr  (DEST_addr),
    .ALU_op     (ALU_op),
    .ALU_src    (ALU_src),
    .REG_write  (REG_write),
    .MEM_read   (MEM_read),
    .MEM_write  (MEM_write),
    .MEM_to_reg (MEM_to_reg),
    .BRANCH     (BRANCH),
    .ILLEGAL    (ILLEGAL)
  );

  // clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // check every control output of the ID/EX register
  task automatic chk_ctrl(input string tag, input logic [2:0] alu, input logic src,
                          input logic rw, input logic mr, input logic mw,
                          input logic m2r, input logic br, input logic ill);
    chk({tag, ".alu_op"},     {29'd0, ALU_op},  {29'd0, alu});
    chk({tag, ".alu_src"},    {31'd0, ALU_src},    {31'd0, src});
    chk({tag, ".reg_write"},  {31'd0, REG_write},  {31'd0, rw});
    chk({tag, ".mem_read"},   {31'd0, MEM_read},   {31'd0, mr});
    chk({tag, ".mem_write"},  {31'd0, MEM_write},  {31'd0, mw});
    chk({tag, ".mem_to_reg"}, {31'd0, MEM_to_reg}, {31'd0, m2r});
    chk({tag, ".branch"},     {31'd0, BRANCH},     {31'd0, br});
    chk({tag, ".illegal"},    {31'd0, ILLEGAL},    {31'd0, ill});
  endtask

  task automatic decode_one(input string tag, input logic [31:0] ir,
                            input logic [31:0] imm, input logic [4:0] dest,
                            input logic [2:0] alu, input logic src, input logic rw,
                            input logic mr, input logic mw, input logic m2r,
                            input logic br, input logic ill);
    IR = ir;
    IF_valid = 1'b1;
    step();
    chk({tag, ".valid"}, {31'd0, ID_valid}, 32'd1);
    chk({tag, ".imm"}, IMM_ext, imm);
    if (!ill && (rw || mr)) chk({tag, ".dest"}, {27'd0, DEST_addr}, {27'd0, dest});
    chk_ctrl(tag, alu, src, rw, mr, mw, m2r, br, ill);
  endtask

  initial begin
    // ---------------- reset ----------------
    RESET = 1'b1; IR = 32'h0; IF_valid = 1'b0; EX_ready = 1'b1;
    WB_en = 1'b0; WB_addr = 5'd0; WB_data = 32'h0;
    step();
    step();
    RESET = 1'b0;
    #1;
    chk("rst.id_ready", {31'd0, ID_ready}, 32'd1);
    chk("rst.id_valid", {31'd0, ID_valid}, 32'd0);
    chk("rst.rs_data", RS_data, 32'h0);
    chk("rst.rt_data", RT_data, 32'h0);
    chk("rst.imm", IMM_ext, 32'h0);
    chk("rst.dest", {27'd0, DEST_addr}, 32'h0);
    chk_ctrl("rst", 3'd0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- write $5, then add $6,$5,$6 ----------------
    WB_en = 1'b1; WB_addr = 5'd5; WB_data = 32'h12345678;
    step();
    WB_en = 1'b0;
    IR = 32'h00A63020; IF_valid = 1'b1;
    step();
    chk("add.valid", {31'd0, ID_valid}, 32'd1);
    chk("add.rs", RS_data, 32'h12345678);
    chk("add.rt", RT_data, 32'h0);
    chk("add.dest", {27'd0, DEST_addr}, 32'd6);
    chk_ctrl("add", 3'd0, 0, 1, 0, 0, 0, 0, 0);

    // ---------------- lw $2,-4($1) ----------------
    IR = 32'h8C22FFFC;
    step();
    chk("lw.imm", IMM_ext, 32'hFFFFFFFC);
    chk("lw.dest", {27'd0, DEST_addr}, 32'd2);
    chk_ctrl("lw", 3'd0, 1, 1, 1, 0, 1, 0, 0);

    // ---------------- bypass: add $3,$1,$2 while writing $1 ----------------
    IR = 32'h00221820;
    WB_en = 1'b1; WB_addr = 5'd1; WB_data = 32'hDEADBEEF;
    step();
    chk("byp.rs", RS_data, 32'hDEADBEEF);
    chk("byp.rt", RT_data, 32'h0);
    chk("byp.dest", {27'd0, DEST_addr}, 32'd3);

    // ---------------- register 0: write 5, no bypass, no store ----------------
    IR = 32'h00000020;
    WB_en = 1'b1; WB_addr = 5'd0; WB_data = 32'h5;
    step();
    chk("r0.bypass", RS_data, 32'h0);
    WB_en = 1'b0;
    IR = 32'h00010020;  // add $0,$0,$1
    step();
    chk("r0.read", RS_data, 32'h0);
    chk("r1.read", RT_data, 32'hDEADBEEF);

    // ---------------- remaining decodes ----------------
    decode_one("sub",  32'h00221822, 32'h00001822, 5'd3, 3'd1, 0, 1, 0, 0, 0, 0, 0);
    decode_one("and",  32'h00221824, 32'h00001824, 5'd3, 3'd2, 0, 1, 0, 0, 0, 0, 0);
    decode_one("or",   32'h00221825, 32'h00001825, 5'd3, 3'd3, 0, 1, 0, 0, 0, 0, 0);
    decode_one("slt",  32'h0022182A, 32'h0000182A, 5'd3, 3'd4, 0, 1, 0, 0, 0, 0, 0);
    decode_one("addi", 32'h2025FFFF, 32'hFFFFFFFF, 5'd5, 3'd0, 1, 1, 0, 0, 0, 0, 0);
    decode_one("sw",   32'hAC220008, 32'h00000008, 5'd2, 3'd0, 1, 0, 0, 1, 0, 0, 0);
    decode_one("beq",  32'h10220003, 32'h00000003, 5'd2, 3'd1, 0, 0, 0, 0, 0, 1, 0);
    decode_one("badfn", 32'h00221821, 32'h00001821, 5'd3, 3'd0, 0, 0, 0, 0, 0, 0, 1);

    // ---------------- stall ----------------
    IR = 32'h00A63020; IF_valid = 1'b1; EX_ready = 1'b1;
    step();
    EX_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      IR = (i == 1) ? 32'hFC000000 : 32'h8C22FFFC;
      WB_en = (i == 0); WB_addr = 5'd6; WB_data = 32'h66;
      step();
      chk("stall.id_ready", {31'd0, ID_ready}, 32'd0);
      chk("stall.valid", {31'd0, ID_valid}, 32'd1);
      chk("stall.rs", RS_data, 32'h12345678);
      chk("stall.rt", RT_data, 32'h0);
      chk("stall.imm", IMM_ext, 32'h00003020);
      chk("stall.dest", {27'd0, DEST_addr}, 32'd6);
      chk_ctrl("stall", 3'd0, 0, 1, 0, 0, 0, 0, 0);
    end
    WB_en = 1'b0;
    EX_ready = 1'b1;
    IR = 32'h00C53820;  // add $7,$6,$5
    #1;
    chk("release.id_ready", {31'd0, ID_ready}, 32'd1);
    step();
    chk("release.rs", RS_data, 32'h66);
    chk("release.rt", RT_data, 32'h12345678);
    chk("release.dest", {27'd0, DEST_addr}, 32'd7);

    // ---------------- illegal opcode, then bubble ----------------
    IR = 32'hFC000000;
    step();
    chk("ill.valid", {31'd0, ID_valid}, 32'd1);
    chk_ctrl("ill", 3'd0, 0, 0, 0, 0, 0, 0, 1);
    IF_valid = 1'b0;
    IR = 32'h8C22FFFC;
    step();
    chk("bubble.valid", {31'd0, ID_valid}, 32'd0);
    chk("bubble.reg_write", {31'd0, REG_write}, 32'd0);
    chk("bubble.mem_read", {31'd0, MEM_read}, 32'd0);
    chk("bubble.illegal", {31'd0, ILLEGAL}, 32'd0);

    // ---------------- reset during stall with a write ----------------
    IR = 32'h00A63020; IF_valid = 1'b1;
    step();
    EX_ready = 1'b0;
    RESET = 1'b1;
    WB_en = 1'b1; WB_addr = 5'd9; WB_data = 32'h99;
    step();
    RESET = 1'b0;
    WB_en = 1'b0;
    chk("rststall.valid", {31'd0, ID_valid}, 32'd0);
    chk("rststall.rs", RS_data, 32'h0);
    chk("rststall.imm", IMM_ext, 32'h0);
    chk("rststall.reg_write", {31'd0, REG_write}, 32'd0);
    chk("rststall.id_ready", {31'd0, ID_ready}, 32'd1);
    EX_ready = 1'b1;
    step();
    chk("rststall.r5", RS_data, 32'h0);
    chk("rststall.r6", RT_data, 32'h0);
    IR = 32'h01260020;  // add $0,$9,$6
    step();
    chk("rststall.r9", RS_data, 32'h0);
    chk("rststall.r6b", RT_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
